// File: rtl/fifo_arb_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_ctrl_pkg
//   Default parameter constants shared by the arbitrated FIFO controller.
//   Width-dependent types live in the modules themselves, because their
//   widths come from per-instance parameters.
// ---------------------------------------------------------------------------
package fifo_arb_ctrl_pkg;

   localparam int DATASIZE_DEF     = 8;  // FIFO word width
   localparam int ADDRSIZE_DEF     = 4;  // memory address bits, depth = 2**ADDRSIZE
   localparam int AFULL_MARGIN_DEF = 2;  // free entries left when almost_full rises

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin arbiter with a 1-bit priority register.
//   Ports:
//     wclk, wrst_n  clock and asynchronous active-low reset
//     req[1:0]      request vector (bit N = requester N)
//     en            grant enable (deasserted while the FIFO is full)
//     gnt[1:0]      one-hot or zero grant, combinational
// ---------------------------------------------------------------------------
module rr_arb2 (
   input  logic       wclk,
   input  logic       wrst_n,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt
);

   // prio names the preferred requester when both ask in the same cycle
   logic prio;

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req[0] && (!req[1] || !prio)) gnt[0] = 1'b1;
         else if (req[1])                  gnt[1] = 1'b1;
      end
   end

   // After any grant the other requester becomes preferred; no grant, no change
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n)     prio <= 1'b0;
      else if (gnt[0]) prio <= 1'b1;
      else if (gnt[1]) prio <= 1'b0;
   end

endmodule

// File: rtl/fifo_arb_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_arb_ctrl
//   Controller for a single-clock FIFO fed by two round-robin arbitrated
//   writers and drained by one reader. The storage array is an external
//   fifomem with a combinational read port.
//   Ports:
//     wclk, wrst_n                 clock, asynchronous active-low reset
//     reqN_valid/reqN_data/reqN_ready  write requester N, ready = accepted
//     rd_en, rd_data, rd_valid     pop request, registered data, 1-cycle valid
//     mem_*                        connection to the external fifomem
//     full, empty, almost_full     status flags from registered pointers
//     count                        occupancy 0 .. 2**ADDRSIZE
//     underflow_err                sticky pop-while-empty indication
// ---------------------------------------------------------------------------
module fifo_arb_ctrl
   import fifo_arb_ctrl_pkg::*;
#(
   parameter int DATASIZE     = DATASIZE_DEF,
   parameter int ADDRSIZE     = ADDRSIZE_DEF,
   parameter int AFULL_MARGIN = AFULL_MARGIN_DEF
) (
   input  logic                wclk,
   input  logic                wrst_n,
   input  logic                req0_valid,
   input  logic [DATASIZE-1:0] req0_data,
   output logic                req0_ready,
   input  logic                req1_valid,
   input  logic [DATASIZE-1:0] req1_data,
   output logic                req1_ready,
   input  logic                rd_en,
   output logic [DATASIZE-1:0] rd_data,
   output logic                rd_valid,
   output logic [DATASIZE-1:0] mem_wdata,
   output logic [ADDRSIZE-1:0] mem_waddr,
   output logic [ADDRSIZE-1:0] mem_raddr,
   output logic                mem_winc,
   output logic                mem_wfull,
   input  logic [DATASIZE-1:0] mem_rdata,
   output logic                full,
   output logic                empty,
   output logic                almost_full,
   output logic [ADDRSIZE:0]   count,
   output logic                underflow_err
);

   localparam int              DEPTH     = 1 << ADDRSIZE;
   localparam logic [ADDRSIZE:0] AFULL_LVL = (ADDRSIZE+1)'(DEPTH - AFULL_MARGIN);
   localparam logic [ADDRSIZE:0] PTR_ONE   = (ADDRSIZE+1)'(1);

   // One extra MSB distinguishes full from empty when the low bits match
   logic [ADDRSIZE:0] wptr;
   logic [ADDRSIZE:0] rptr;
   logic [1:0]        gnt;
   logic              rd_fire;

   assign full        = (wptr[ADDRSIZE] != rptr[ADDRSIZE]) &&
                        (wptr[ADDRSIZE-1:0] == rptr[ADDRSIZE-1:0]);
   assign empty       = (wptr == rptr);
   assign count       = wptr - rptr;
   assign almost_full = (count >= AFULL_LVL);

   assign mem_waddr = wptr[ADDRSIZE-1:0];
   assign mem_raddr = rptr[ADDRSIZE-1:0];
   assign mem_wfull = full;

   rr_arb2 u_arb (
      .wclk   (wclk),
      .wrst_n (wrst_n),
      .req    ({req1_valid, req0_valid}),
      .en     (!full),
      .gnt    (gnt)
   );

   assign req0_ready = gnt[0];
   assign req1_ready = gnt[1];
   assign mem_winc   = |gnt;
   assign mem_wdata  = gnt[1] ? req1_data : req0_data;

   // Full refuses writes even if a pop happens the same cycle; the freed
   // slot is seen only once rptr has advanced.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n)       wptr <= '0;
      else if (mem_winc) wptr <= wptr + PTR_ONE;
   end

   // No write-to-read bypass: a word written into an empty FIFO is popped
   // no earlier than the following cycle.
   assign rd_fire = rd_en && !empty;

   // ---- read stage: pop request -> registered rd_data/rd_valid ----
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         rptr          <= '0;
         rd_data       <= '0;
         rd_valid      <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         rd_valid <= rd_fire;
         if (rd_fire) begin
            rd_data <= mem_rdata;
            rptr    <= rptr + PTR_ONE;
         end
         if (rd_en && empty) underflow_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
module tb_fifo_arb_ctrl;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          wclk;
   logic          wrst_n;
   logic          req0_valid, req1_valid;
   logic [DW-1:0] req0_data, req1_data;
   logic          req0_ready, req1_ready;
   logic          rd_en;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic [DW-1:0] mem_wdata;
   logic [AW-1:0] mem_waddr, mem_raddr;
   logic          mem_winc, mem_wfull;
   logic [DW-1:0] mem_rdata;
   logic          full, empty, almost_full;
   logic [AW:0]   count;
   logic          underflow_err;

   int checks   = 0;
   int failures = 0;

   fifo_arb_ctrl #(.DATASIZE(DW), .ADDRSIZE(AW), .AFULL_MARGIN(2)) dut (
      .wclk          (wclk),
      .wrst_n        (wrst_n),
      .req0_valid    (req0_valid),
      .req0_data     (req0_data),
      .req0_ready    (req0_ready),
      .req1_valid    (req1_valid),
      .req1_data     (req1_data),
      .req1_ready    (req1_ready),
      .rd_en         (rd_en),
      .rd_data       (rd_data),
      .rd_valid      (rd_valid),
      .mem_wdata     (mem_wdata),
      .mem_waddr     (mem_waddr),
      .mem_raddr     (mem_raddr),
      .mem_winc      (mem_winc),
      .mem_wfull     (mem_wfull),
      .mem_rdata     (mem_rdata),
      .full          (full),
      .empty         (empty),
      .almost_full   (almost_full),
      .count         (count),
      .underflow_err (underflow_err)
   );

   // External fifomem: synchronous write, combinational read
   logic [DW-1:0] mem [DEPTH];
   always @(posedge wclk) if (mem_winc && !mem_wfull) mem[mem_waddr] <= mem_wdata;
   assign mem_rdata = mem[mem_raddr];

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   // Reference model: plain queue of stored words plus arbitration preference
   logic [DW-1:0] q[$];
   bit            prio_m;
   bit            uf_m;
   logic [DW-1:0] exp_rd;
   bit            exp_rv;
   bit            exp_rdy0, exp_rdy1;
   logic [DW-1:0] exp_wdata;
   logic          obs_rdy0, obs_rdy1, obs_winc;
   logic [DW-1:0] obs_wdata;

   task automatic model_reset();
      q.delete();
      prio_m = 1'b0;
      uf_m   = 1'b0;
      exp_rd = '0;
      exp_rv = 1'b0;
   endtask

   task automatic idle_inputs();
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_data  = '0;   req1_data  = '0;
      rd_en      = 1'b0;
   endtask

   // Called at posedge+1; returns at the next posedge+1
   task automatic do_reset();
      idle_inputs();
      wrst_n = 1'b0;
      @(posedge wclk); #1;
      wrst_n = 1'b1;
      model_reset();
   endtask

   // One clock of stimulus; model advances and expectations are recorded
   task automatic step(input bit v0, input logic [DW-1:0] d0,
                       input bit v1, input logic [DW-1:0] d1, input bit re);
      int n;
      bit gr;
      bit win;
      req0_valid = v0; req0_data = d0;
      req1_valid = v1; req1_data = d1;
      rd_en      = re;
      #1;
      obs_rdy0  = req0_ready;
      obs_rdy1  = req1_ready;
      obs_winc  = mem_winc;
      obs_wdata = mem_wdata;
      n   = q.size();
      gr  = (n < DEPTH) && (v0 || v1);
      win = (v0 && v1) ? prio_m : v1;
      exp_rdy0  = gr && !win;
      exp_rdy1  = gr && win;
      exp_wdata = win ? d1 : d0;
      @(posedge wclk); #1;
      if (re && n > 0) begin
         exp_rv = 1'b1;
         exp_rd = q.pop_front();
      end else begin
         exp_rv = 1'b0;
         if (re) uf_m = 1'b1;
      end
      if (gr) begin
         q.push_back(exp_wdata);
         prio_m = !win;
      end
      idle_inputs();
   endtask

   task automatic test_reset();
      idle_inputs();
      wrst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge wclk);
      #1;
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b want=1", empty); end
      checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b want=0", full); end
      checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_afull got=%b want=0", almost_full); end
      checks++; if (count !== '0) begin failures++; $display("FAIL reset_count got=%0d want=0", count); end
      checks++; if (rd_valid !== 1'b0 || rd_data !== '0) begin failures++; $display("FAIL reset_rd got=%b/%h want=0/00", rd_valid, rd_data); end
      checks++; if (underflow_err !== 1'b0) begin failures++; $display("FAIL reset_uf got=%b want=0", underflow_err); end
      wrst_n = 1'b1;
      @(posedge wclk); #1;
   endtask

   task automatic test_alternate();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 8'hA1, 1'b1, 8'hB2, 1'b0);
         checks++;
         if (obs_rdy0 !== exp_rdy0 || obs_rdy1 !== exp_rdy1 || obs_rdy0 !== (i % 2 == 0)) begin
            failures++; $display("FAIL alt_grant%0d got=%b%b want=%b%b", i, obs_rdy1, obs_rdy0, exp_rdy1, exp_rdy0);
         end
         checks++;
         if (obs_wdata !== exp_wdata) begin failures++; $display("FAIL alt_wdata%0d got=%h want=%h", i, obs_wdata, exp_wdata); end
      end
      checks++; if (count !== 5'd4) begin failures++; $display("FAIL alt_count got=%0d want=4", count); end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, '0, 1'b0, '0, 1'b1);
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== exp_rd || rd_data !== ((i % 2 == 0) ? 8'hA1 : 8'hB2)) begin
            failures++; $display("FAIL alt_read%0d got=%b/%h want=1/%h", i, rd_valid, rd_data, exp_rd);
         end
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, 8'($urandom), 1'b0, '0, 1'b0);
         checks++;
         if (count !== 5'(q.size()) || almost_full !== (q.size() >= DEPTH - 2) || full !== (q.size() == DEPTH)) begin
            failures++;
            $display("FAIL fill%0d got cnt=%0d af=%b f=%b want cnt=%0d", i, count, almost_full, full, q.size());
         end
      end
      checks++; if (full !== 1'b1 || count !== 5'd16) begin failures++; $display("FAIL fill_full got f=%b cnt=%0d want 1/16", full, count); end
      step(1'b1, 8'h55, 1'b1, 8'h66, 1'b0);
      checks++;
      if (obs_rdy0 !== 1'b0 || obs_rdy1 !== 1'b0 || obs_winc !== 1'b0) begin
         failures++; $display("FAIL full_refuse got rdy=%b%b winc=%b want 000", obs_rdy1, obs_rdy0, obs_winc);
      end
   endtask

   task automatic test_full_read();
      step(1'b1, 8'h3C, 1'b0, '0, 1'b1);
      checks++; if (obs_rdy0 !== 1'b0) begin failures++; $display("FAIL fullrd_ready got=%b want=0", obs_rdy0); end
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_rd || count !== 5'd15) begin
         failures++; $display("FAIL fullrd_read got=%b/%h cnt=%0d want=1/%h cnt=15", rd_valid, rd_data, count, exp_rd);
      end
      step(1'b1, 8'h3C, 1'b0, '0, 1'b0);
      checks++;
      if (obs_rdy0 !== 1'b1 || count !== 5'd16) begin
         failures++; $display("FAIL fullrd_next got rdy=%b cnt=%0d want 1/16", obs_rdy0, count);
      end
   endtask

   task automatic test_underflow();
      do_reset();
      step(1'b0, '0, 1'b0, '0, 1'b1);
      checks++;
      if (rd_valid !== 1'b0 || underflow_err !== 1'b1 || count !== '0 || empty !== 1'b1 || rd_data !== '0) begin
         failures++; $display("FAIL uf_set got v=%b uf=%b cnt=%0d d=%h want 0/1/0/00", rd_valid, underflow_err, count, rd_data);
      end
      step(1'b1, 8'h77, 1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b0, '0, 1'b1);
      checks++;
      if (underflow_err !== 1'b1 || rd_data !== 8'h77 || rd_data !== exp_rd) begin
         failures++; $display("FAIL uf_hold got uf=%b d=%h want 1/77", underflow_err, rd_data);
      end
      do_reset();
      checks++; if (underflow_err !== 1'b0) begin failures++; $display("FAIL uf_clear got=%b want=0", underflow_err); end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0, '0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 8'($urandom), 1'b0, '0, 1'b1);
         checks++;
         if (count !== 5'd8 || rd_valid !== 1'b1 || rd_data !== exp_rd) begin
            failures++; $display("FAIL wrap%0d got cnt=%0d v=%b d=%h want 8/1/%h", i, count, rd_valid, rd_data, exp_rd);
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, '0, 1'b0);
      checks++; if (count !== 5'd5) begin failures++; $display("FAIL ares_pre got=%0d want=5", count); end
      #2;
      wrst_n = 1'b0;
      #1;
      checks++;
      if (empty !== 1'b1 || count !== '0 || full !== 1'b0 || almost_full !== 1'b0) begin
         failures++; $display("FAIL ares_now got e=%b cnt=%0d f=%b af=%b want 1/0/0/0", empty, count, full, almost_full);
      end
      @(posedge wclk); #1;
      wrst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_random();
      bit v0, v1, re;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         v0 = ($urandom_range(0, 3) != 0);
         v1 = ($urandom_range(0, 2) == 0);
         re = ($urandom_range(0, 1) == 1);
         step(v0, 8'($urandom), v1, 8'($urandom), re);
         checks++;
         if (obs_rdy0 !== exp_rdy0 || obs_rdy1 !== exp_rdy1 || (obs_winc && obs_wdata !== exp_wdata)) begin
            failures++; $display("FAIL rnd_grant%0d got=%b%b/%h want=%b%b/%h", i, obs_rdy1, obs_rdy0, obs_wdata, exp_rdy1, exp_rdy0, exp_wdata);
         end
         checks++;
         if (rd_valid !== exp_rv || rd_data !== exp_rd) begin
            failures++; $display("FAIL rnd_read%0d got=%b/%h want=%b/%h", i, rd_valid, rd_data, exp_rv, exp_rd);
         end
         checks++;
         if (count !== 5'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH) ||
             almost_full !== (q.size() >= DEPTH - 2) || underflow_err !== uf_m) begin
            failures++; $display("FAIL rnd_flags%0d got cnt=%0d e=%b f=%b af=%b uf=%b want cnt=%0d uf=%b",
                                 i, count, empty, full, almost_full, underflow_err, q.size(), uf_m);
         end
      end
   endtask

   initial begin
      test_reset();
      test_alternate();
      test_fill();
      test_full_read();
      test_underflow();
      test_wrap();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_arb_ctrl.md
FIFO_ARB_CTRL -- requirements
Module: fifo_arb_ctrl

Interface
REQ-001 SHALL have parameter DATASIZE, default 8, FIFO word width.
REQ-002 SHALL have parameter ADDRSIZE, default 4, memory address bits; depth = 2^ADDRSIZE.
REQ-003 SHALL have parameter AFULL_MARGIN, default 2, free-entry threshold for almost_full.
REQ-004 SHALL have ports, one clock and one reset; reset is asynchronous and active-low:
  wclk  in  1  sole clock, all state on rising edge
  wrst_n  in  1  asynchronous active-low reset
  req0_valid / req1_valid  in  1  write request from requester 0 / 1
  req0_data / req1_data  in  DATASIZE  write data from requester 0 / 1
  req0_ready / req1_ready  out  1  grant; write accepted this cycle
  rd_en  in  1  pop request
  rd_data  out  DATASIZE  registered pop data
  rd_valid  out  1  rd_data valid, one-cycle pulse
  mem_wdata  out  DATASIZE  to fifomem wdata
  mem_waddr / mem_raddr  out  ADDRSIZE  to fifomem waddr / raddr
  mem_winc  out  1  to fifomem winc
  mem_wfull  out  1  to fifomem wfull
  mem_rdata  in  DATASIZE  from fifomem rdata (combinational read)
  full / empty / almost_full  out  1  status flags
  count  out  ADDRSIZE+1  occupancy
  underflow_err  out  1  sticky pop-while-empty flag

Function
REQ-005 SHALL keep wptr and rptr as ADDRSIZE+1-bit binary counters; mem_waddr/mem_raddr = low ADDRSIZE bits.
REQ-006 SHALL derive full = (MSBs differ, low bits equal), empty = (wptr == rptr), count = wptr - rptr modulo 2^(ADDRSIZE+1), all from registered pointers only.
REQ-007 SHALL assert almost_full when count >= 2^ADDRSIZE - AFULL_MARGIN.
REQ-008 SHALL grant at most one requester per cycle, only when !full; readyN combinational from valids, full and the priority register.
REQ-009 SHALL arbitrate round-robin: a 1-bit priority register names the preferred requester; after a grant it points to the non-granted requester; no grant leaves it unchanged.
REQ-010 SHALL, on a grant, drive mem_wdata = granted data, mem_winc = 1, and increment wptr at that edge; mem_winc = 0 otherwise; mem_wfull = full.
REQ-011 SHALL, on rd_en && !empty, capture mem_rdata into rd_data, pulse rd_valid the next cycle, and increment rptr (latency 1 cycle).
REQ-012 SHALL ignore rd_en when empty (no pointer change, rd_valid = 0, rd_data held) and set underflow_err, which holds until reset.
REQ-013 SHALL, on a simultaneous write and read, perform both; count unchanged.
REQ-014 SHALL, when full, refuse writes even when a read occurs the same cycle; the slot frees the next cycle.
REQ-015 SHALL, when empty, not bypass a same-cycle write to the read port; the word is readable the next cycle.
REQ-016 SHALL wrap pointers naturally at 2^(ADDRSIZE+1), with full/empty correct across wrap.

Reset
REQ-017 SHALL, on wrst_n low, clear wptr, rptr, the priority register (requester 0 preferred), rd_data, rd_valid and underflow_err immediately: empty = 1, full = 0, almost_full = 0, count = 0.
REQ-018 SHALL discard FIFO contents on reset mid-operation; memory array contents are don't-care and not cleared.

Structure
REQ-019 SHALL place no DATASIZE/ADDRSIZE-dependent types in a package; a shared package SHALL hold only the default parameter constants.
REQ-020 SHALL instantiate no memory internally; it connects to an external fifomem. One sub-module, rr_arb2 (2-way round-robin grant plus priority register), is natural.

Verification
REQ-021 Reset, then both valids high with data 0xA1/0xB2 for 4 cycles -> grants alternate 0,1,0,1; count = 4; reads return A1,B2,A1,B2.
REQ-022 Write 16 words (ADDRSIZE = 4) -> full = 1 and count = 16 after the 16th; further valid -> ready = 0, no mem_winc; almost_full first high at count = 14.
REQ-023 Full FIFO, rd_en plus req0_valid the same cycle -> read only, count = 15; the write is granted the next cycle.
REQ-024 Empty FIFO, rd_en = 1 -> rd_valid = 0, pointers unchanged, underflow_err = 1 and held until wrst_n pulse.
REQ-025 Run 40 writes/reads interleaved at count = 8 -> pointers wrap twice; data order preserved; count stays 8.
REQ-026 Assert wrst_n low with count = 5 -> empty = 1 and count = 0 immediately, before the next wclk edge.
